// File: rtl/wb_pkg.sv
// Shared types and width helpers for the multi-lane write-back stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wb_pkg;
    localparam int WB_REG_W  = 5;
    localparam int WB_DATA_W = 32;
    localparam int REG_ZERO  = 0;

    // One buffered register-file write at the default widths.
    typedef struct packed {
        logic [WB_REG_W-1:0]  rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction
endpackage

// File: rtl/wb_multi_lane_if.sv
// Bundle of retiring-lane inputs and register-file write-port outputs.
// Latency: none (wiring only).
// Backpressure: in_ready is driven by the stage, the upstream holds inputs while it is low.
interface wb_multi_lane_if
    import wb_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int WR_PORTS = 1,
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5
) ();
    logic [LANES-1:0]          in_valid;
    logic [LANES-1:0]          in_mem_to_reg;
    logic [LANES*DATA_W-1:0]   in_alu_result;
    logic [LANES*DATA_W-1:0]   in_mem_data;
    logic [LANES*REG_W-1:0]    in_write_reg;
    logic                      in_ready;
    logic [WR_PORTS-1:0]       wb_valid_OUT;
    logic [WR_PORTS*REG_W-1:0] wb_reg_OUT;
    logic [WR_PORTS*DATA_W-1:0] wb_data_OUT;
    logic [cnt_w(DEPTH)-1:0]   occupancy_OUT;

    modport master (
        output in_valid, in_mem_to_reg, in_alu_result, in_mem_data, in_write_reg,
        input  in_ready, wb_valid_OUT, wb_reg_OUT, wb_data_OUT, occupancy_OUT
    );

    modport slave (
        input  in_valid, in_mem_to_reg, in_alu_result, in_mem_data, in_write_reg,
        output in_ready, wb_valid_OUT, wb_reg_OUT, wb_data_OUT, occupancy_OUT
    );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer taking up to PUSH compacted entries and releasing up to POP per cycle.
// Latency: an entry pushed at an edge is poppable from the next edge.
// Backpressure: none internally; the caller only pushes when free space covers a full bundle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int W     = 37,
    parameter int PUSH  = 2,
    parameter int POP   = 1,
    parameter int DEPTH = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [cnt_w(DEPTH)-1:0] push_cnt,
    input  logic [W-1:0]            push_dat [PUSH],
    output logic [W-1:0]            pop_dat  [POP],
    output logic [cnt_w(DEPTH)-1:0] pop_cnt,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic [cnt_w(DEPTH)-1:0] count_next
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Pop as many as are buffered, up to the port count; new pushes only land after this edge.
    always_comb begin
        pop_cnt    = (count < CNT_W'(POP)) ? count : CNT_W'(POP);
        count_next = count - pop_cnt + push_cnt;
        for (int p = 0; p < POP; p++) begin
            pop_dat[p] = mem[head + PTR_W'(p)];
        end
    end

    // Storage writes at consecutive slots from tail; no reset needed for payload.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < PUSH; i++) begin
            if (CNT_W'(i) < push_cnt) begin
                mem[tail + PTR_W'(i)] <= push_dat[i];
            end
        end
    end

    // Pointer and count update; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_cnt);
            tail  <= tail + PTR_W'(push_cnt);
            count <= count_next;
        end
    end
endmodule

// File: rtl/wb_multi_lane.sv
// Multi-lane write-back: selects result per lane, drops r0 writes, buffers in order, drains onto write ports.
// Latency: a result accepted at one edge reaches the write ports after the following edge at the earliest.
// Backpressure: in_ready low whenever free space is below a full LANES bundle; inputs are ignored then.
module wb_multi_lane
    import wb_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int WR_PORTS = 1,
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5
) (
    input  logic           CLK,
    input  logic           RESET,
    wb_multi_lane_if.slave bus
);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int ENT_W = REG_W + DATA_W;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             lane_ent [LANES];
    logic [LANES-1:0]   keep;
    logic [CNT_W-1:0]   slot     [LANES];
    logic [CNT_W-1:0]   kept_cnt;
    logic [CNT_W-1:0]   push_cnt;
    logic [CNT_W-1:0]   pop_cnt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [ENT_W-1:0]   push_dat [LANES];
    logic [ENT_W-1:0]   pop_dat  [WR_PORTS];
    entry_t             head_ent [WR_PORTS];
    logic [WR_PORTS-1:0] port_live;

    // Per-lane source select and zero-register filter.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_ent[i].rd   = bus.in_write_reg[i*REG_W +: REG_W];
            lane_ent[i].data = bus.in_mem_to_reg[i] ? bus.in_mem_data[i*DATA_W +: DATA_W]
                                                    : bus.in_alu_result[i*DATA_W +: DATA_W];
            keep[i]          = bus.in_valid[i] && (lane_ent[i].rd != REG_W'(REG_ZERO));
        end
    end

    // Compact surviving lanes into consecutive push slots, preserving lane (program) order.
    always_comb begin
        kept_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = kept_cnt;
            if (keep[i]) kept_cnt = kept_cnt + CNT_W'(1);
        end
        for (int j = 0; j < LANES; j++) begin
            push_dat[j] = '0;
            for (int i = 0; i < LANES; i++) begin
                if (keep[i] && slot[i] == CNT_W'(j)) push_dat[j] = lane_ent[i];
            end
        end
    end

    // Space check uses the registered count only, so a drain this cycle gives no extra credit.
    assign bus.in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(LANES);
    assign push_cnt     = bus.in_ready ? kept_cnt : '0;

    wb_fifo #(
        .W     (ENT_W),
        .PUSH  (LANES),
        .POP   (WR_PORTS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push_cnt   (push_cnt),
        .push_dat   (push_dat),
        .pop_dat    (pop_dat),
        .pop_cnt    (pop_cnt),
        .count      (count),
        .count_next (count_next)
    );

    // Coalesce same-register writes within one drain group: the youngest port wins.
    always_comb begin
        for (int p = 0; p < WR_PORTS; p++) begin
            head_ent[p] = entry_t'(pop_dat[p]);
        end
        for (int p = 0; p < WR_PORTS; p++) begin
            port_live[p] = CNT_W'(p) < pop_cnt;
            for (int q = p + 1; q < WR_PORTS; q++) begin
                if (CNT_W'(q) < pop_cnt && head_ent[q].rd == head_ent[p].rd) port_live[p] = 1'b0;
            end
        end
    end

    // Registered write ports; idle ports drop valid but keep their last reg/data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.wb_valid_OUT  <= '0;
            bus.wb_reg_OUT    <= '0;
            bus.wb_data_OUT   <= '0;
            bus.occupancy_OUT <= '0;
        end else begin
            bus.occupancy_OUT <= count_next;
            for (int p = 0; p < WR_PORTS; p++) begin
                bus.wb_valid_OUT[p] <= port_live[p];
                if (CNT_W'(p) < pop_cnt) begin
                    bus.wb_reg_OUT[p*REG_W +: REG_W]    <= head_ent[p].rd;
                    bus.wb_data_OUT[p*DATA_W +: DATA_W] <= head_ent[p].data;
                end
            end
        end
    end
endmodule
